mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 36 +++
 rtl/mul_div_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared MIPS definitions: ALU operation codes, HI/LO funct codes, helpers.
package mul_div_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 5;

  // ALU operation codes used by the execute stage
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;

  // R-type funct codes handled by the multiply/divide unit
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Magnitude of a 32-bit operand; 0x80000000 maps to unsigned 2^31
  function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Multiply and divide share one 64-bit shift register and one 33-bit adder.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [5:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;
  logic [31:0]      opd;
  logic [31:0]      a_raw;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic             op_mul;
  logic             op_div;
  logic             op_sgn;
  logic [32:0]      add_x;
  logic [32:0]      add_y;
  logic [32:0]      add_s;
  logic [32:0]      mul_hi;
  logic             div_ok;
  logic [31:0]      div_rem;
  logic [63:0]      prod;

  // Request decode
  always_comb begin
    op_mul = (OP == FN_MULT) || (OP == FN_MULTU);
    op_div = (OP == FN_DIV) || (OP == FN_DIVU);
    op_sgn = (OP == FN_MULT) || (OP == FN_DIV);
  end

  // Shared 33-bit adder: add multiplicand, or subtract divisor from shifted remainder
  always_comb begin
    add_x   = is_div ? {1'b0, acc[62:31]} : {1'b0, acc[63:32]};
    add_y   = is_div ? ~{1'b0, opd} : {1'b0, opd};
    add_s   = add_x + add_y + 33'(is_div);
    mul_hi  = acc[0] ? add_s : {1'b0, acc[63:32]};
    div_ok  = acc[63] | ~add_s[32];
    div_rem = div_ok ? add_s[31:0] : acc[62:31];
    prod    = neg_q ? 64'(-acc) : acc;
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (op_mul || op_div) begin
              acc    <= {32'd0, op_mul ? mag32(B, op_sgn) : mag32(A, op_sgn)};
              opd    <= op_mul ? mag32(A, op_sgn) : mag32(B, op_sgn);
              a_raw  <= A;
              is_div <= op_div;
              neg_q  <= op_sgn & (A[31] ^ B[31]);
              neg_r  <= op_sgn & A[31];
              cnt    <= '0;
              BUSY   <= 1'b1;
              state  <= op_mul ? S_MUL : S_DIV;
            end else if (OP == FN_MTHI) begin
              HI <= A;
            end else if (OP == FN_MTLO) begin
              LO <= A;
            end
          end
        end
        S_MUL: begin
          acc <= {mul_hi, acc[31:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(31)) state <= S_FIX;
        end
        S_DIV: begin
          acc <= {div_rem, acc[30:0], div_ok};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(31)) state <= S_FIX;
        end
        S_FIX: begin
          if (!is_div) begin
            HI <= prod[63:32];
            LO <= prod[31:0];
          end else if (opd == 32'd0) begin
            HI <= a_raw;
            LO <= 32'hFFFF_FFFF;
          end else begin
            HI <= neg_r ? 32'(-acc[63:32]) : acc[63:32];
            LO <= neg_q ? 32'(-acc[31:0]) : acc[31:0];
          end
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
